ts_packet_arbiter: RTL and testbench

Parametrised N-channel transport-stream packet multiplexer, the next generation of the fixed 4-input source switch. It sits between the per-tuner `reclock_and_prepare` FIFOs and the output FIFO in the `SYS_CLK` domain. It grants whole packets round-robin among ready, SPI-enabled sources, and drives a byte stream with `D_VALID_OUT`/`P_SYNC_OUT`. When all enabled sources stay silent, it can insert null packets (PID 0x1FFF) to keep the downstream ASI path alive.

---
 rtl/ts_pkg.sv | 38 +++
 rtl/ts_packet_arbiter_if.sv | 28 ++
 rtl/rr_arbiter.sv | 35 +++
 rtl/ts_packet_arbiter.sv | 165 ++++++++++++++++
 tb/tb_ts_packet_arbiter.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ts_pkg.sv
// Shared constants and types for the transport-stream packet arbiter:
// sync/null-packet bytes, FSM state encoding and the output pipeline record.
package ts_pkg;

  localparam logic [7:0] TS_SYNC    = 8'h47;
  localparam logic [7:0] NULL_HDR_1 = 8'h1F;
  localparam logic [7:0] NULL_HDR_2 = 8'hFF;
  localparam logic [7:0] NULL_HDR_3 = 8'h10;
  localparam logic [7:0] NULL_STUFF = 8'hFF;
  localparam logic [2:0] NULL_CH    = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    NULL = 2'd2
  } state_t;

  // One byte slot travelling from the request cycle to the output register.
  typedef struct packed {
    logic       valid;
    logic       sync;
    logic       is_null;
    logic [2:0] ch;
    logic [7:0] data;
  } slot_t;

  // Null packet (PID 0x1FFF) content by byte index.
  function automatic logic [7:0] null_byte(input logic [7:0] idx);
    case (idx)
      8'd0:    return TS_SYNC;
      8'd1:    return NULL_HDR_1;
      8'd2:    return NULL_HDR_2;
      8'd3:    return NULL_HDR_3;
      default: return NULL_STUFF;
    endcase
  endfunction

endpackage

// File: rtl/ts_packet_arbiter_if.sv
// Source-FIFO, SPI-config and output-stream signals of the packet arbiter,
// with modports for the arbiter (slave) and its environment (master).
interface ts_packet_arbiter_if #(
  parameter int N_CH = 4
);

  logic [N_CH-1:0]   GOT_FULL_PACKET;
  logic [8*N_CH-1:0] DATA_IN;
  logic [7:0]        SPI_ADDRESS;
  logic [7:0]        SPI_DATA;
  logic              RISING_SS;
  logic [N_CH-1:0]   RD_REQ;
  logic [7:0]        DATA_OUT;
  logic              D_VALID_OUT;
  logic              P_SYNC_OUT;
  logic [2:0]        CUR_CH;

  modport slave (
    input  GOT_FULL_PACKET, DATA_IN, SPI_ADDRESS, SPI_DATA, RISING_SS,
    output RD_REQ, DATA_OUT, D_VALID_OUT, P_SYNC_OUT, CUR_CH
  );

  modport master (
    output GOT_FULL_PACKET, DATA_IN, SPI_ADDRESS, SPI_DATA, RISING_SS,
    input  RD_REQ, DATA_OUT, D_VALID_OUT, P_SYNC_OUT, CUR_CH
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first request strictly after ptr, with
// wrap-around; the pointer itself is owned by the caller.
module rr_arbiter #(
  parameter  int N_CH  = 4,
  localparam int PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic [N_CH-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_CH-1:0]  grant,
  output logic [PTR_W-1:0] grant_idx,
  output logic             valid
);

  logic             found;
  logic [PTR_W-1:0] idx;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the loop leaves a value held, which would infer a latch.
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    valid     = |req;
    for (int k = 1; k <= N_CH; k++) begin
      idx = PTR_W'((int'(ptr) + k) % N_CH);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/ts_packet_arbiter.sv
// N-channel TS packet multiplexer: round-robin whole-packet grants, optional
// null-packet stuffing on idle, registered byte stream with sync marker.
module ts_packet_arbiter
  import ts_pkg::*;
#(
  parameter int         N_CH      = 4,
  parameter int         PKT_LEN   = 188,
  parameter logic [7:0] CFG_ADDR  = 8'h10,
  parameter int         NULL_IDLE = 2048
) (
  input logic              SYS_CLK,
  input logic              RST,
  ts_packet_arbiter_if.slave bus
);

  localparam int PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CNT_W = $clog2(PKT_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PKT_LEN - 1);
  localparam logic [15:0]      IDLE_THR = 16'(NULL_IDLE - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      idle_q, idle_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] grant_q, grant_d;
  logic [N_CH-1:0]  mask_q, mask_d;
  logic             null_en_q, null_en_d;
  logic [N_CH-1:0]  rd_req_q, rd_req_d;
  logic [2:0]       cur_ch_q, cur_ch_d;
  slot_t            s1_q, s1_d;
  logic [7:0]       data_out_q, data_out_d;
  logic             d_valid_q, d_valid_d;
  logic             p_sync_q, p_sync_d;

  logic [N_CH-1:0]  arb_grant;
  logic [PTR_W-1:0] arb_idx;
  logic             arb_valid;
  logic             unused_spi_data;

  rr_arbiter #(.N_CH(N_CH)) u_rr (
    .req       (bus.GOT_FULL_PACKET & mask_q),
    .ptr       (ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .valid     (arb_valid)
  );

  assign unused_spi_data = ^bus.SPI_DATA;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idle_d     = idle_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    mask_d     = mask_q;
    null_en_d  = null_en_q;
    rd_req_d   = '0;
    cur_ch_d   = cur_ch_q;
    s1_d       = '0;
    data_out_d = data_out_q;
    d_valid_d  = s1_q.valid;
    p_sync_d   = s1_q.valid & s1_q.sync;

    // FIFO data for a slot arrives one cycle after its request, so the
    // output mux works on the delayed slot record.
    if (s1_q.valid) begin
      data_out_d = s1_q.is_null ? s1_q.data : bus.DATA_IN[8*s1_q.ch +: 8];
    end

    if (bus.RISING_SS) begin
      if (bus.SPI_ADDRESS == CFG_ADDR) begin
        mask_d = bus.SPI_DATA[N_CH-1:0];
      end else if (bus.SPI_ADDRESS == CFG_ADDR + 8'd1) begin
        null_en_d = bus.SPI_DATA[0];
      end
    end

    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          state_d  = READ;
          ptr_d    = arb_idx;
          grant_d  = arb_idx;
          rd_req_d = arb_grant;
          cur_ch_d = 3'(arb_idx);
          idle_d   = '0;
        end else begin
          if (idle_q != 16'hFFFF) idle_d = idle_q + 16'd1;
          if (null_en_q && idle_q >= IDLE_THR) begin
            state_d  = NULL;
            cur_ch_d = NULL_CH;
            idle_d   = '0;
          end
        end
      end
      READ: begin
        s1_d.valid = 1'b1;
        s1_d.sync  = (cnt_q == '0);
        s1_d.ch    = 3'(grant_q);
        if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d    = cnt_q + 1'b1;
          rd_req_d = rd_req_q;
        end
      end
      NULL: begin
        s1_d.valid   = 1'b1;
        s1_d.sync    = (cnt_q == '0);
        s1_d.is_null = 1'b1;
        s1_d.data    = null_byte(8'(cnt_q));
        if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge SYS_CLK or posedge RST) begin
    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values of the others, independent of statement order.
    if (RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idle_q     <= '0;
      ptr_q      <= PTR_W'(N_CH - 1);
      grant_q    <= '0;
      mask_q     <= '1;
      null_en_q  <= 1'b0;
      rd_req_q   <= '0;
      cur_ch_q   <= '0;
      s1_q       <= '0;
      data_out_q <= '0;
      d_valid_q  <= 1'b0;
      p_sync_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idle_q     <= idle_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      mask_q     <= mask_d;
      null_en_q  <= null_en_d;
      rd_req_q   <= rd_req_d;
      cur_ch_q   <= cur_ch_d;
      s1_q       <= s1_d;
      data_out_q <= data_out_d;
      d_valid_q  <= d_valid_d;
      p_sync_q   <= p_sync_d;
    end
  end

  assign bus.RD_REQ      = rd_req_q;
  assign bus.DATA_OUT    = data_out_q;
  assign bus.D_VALID_OUT = d_valid_q;
  assign bus.P_SYNC_OUT  = p_sync_q;
  assign bus.CUR_CH      = cur_ch_q;

endmodule

// File: tb/tb_ts_packet_arbiter.sv
// Scoreboard bench for ts_packet_arbiter: FIFO models push expected bytes on
// each pop, a negedge monitor pops and compares them plus grant order and gaps.
module tb_ts_packet_arbiter;
  import ts_pkg::*;

  localparam int N_CH      = 4;
  localparam int PKT_LEN   = 188;
  localparam int NULL_IDLE = 16;

  typedef struct { logic [7:0] data; logic sync; } exp_byte_t;
  typedef struct { int ch; int gap; } exp_pkt_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ts_packet_arbiter_if #(.N_CH(N_CH)) bus ();

  ts_packet_arbiter #(
    .N_CH(N_CH), .PKT_LEN(PKT_LEN), .CFG_ADDR(8'h10), .NULL_IDLE(NULL_IDLE)
  ) dut (
    .SYS_CLK (clk),
    .RST     (rst),
    .bus     (bus)
  );

  exp_byte_t sb[$];
  exp_pkt_t  order_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int pop_k[N_CH];
  int vrun, grun, sync_seen, last_idx, last_cyc;
  int rd_run[N_CH];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] src_byte(input int ch, input int k);
    if (k % PKT_LEN == 0) return 8'h47;
    return 8'((ch * 53 + k * 7 + 3) & 255);
  endfunction

  function automatic logic [7:0] null_exp(input int k);
    case (k)
      0:       return 8'h47;
      1:       return 8'h1F;
      2:       return 8'hFF;
      3:       return 8'h10;
      default: return 8'hFF;
    endcase
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Source FIFOs: data appears one cycle after the pop strobe.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) pop_k[i] <= 0;
      bus.DATA_IN <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (bus.RD_REQ[i]) begin
          bus.DATA_IN[8*i +: 8] <= src_byte(i, pop_k[i]);
          sb.push_back('{src_byte(i, pop_k[i]), (pop_k[i] % PKT_LEN) == 0});
          pop_k[i] <= pop_k[i] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_byte_t e;
    exp_pkt_t  o;
    if (rst) begin
      vrun = 0; grun = 0; last_idx = -1;
      for (int i = 0; i < N_CH; i++) rd_run[i] = 0;
    end else begin
      check("rd_req_onehot", 32'($onehot0(bus.RD_REQ)), 1);
      for (int i = 0; i < N_CH; i++) begin
        if (bus.RD_REQ[i]) rd_run[i]++;
        else if (rd_run[i] != 0) begin
          check($sformatf("rd_pulses_ch%0d", i), rd_run[i], PKT_LEN);
          rd_run[i] = 0;
        end
      end
      if (bus.D_VALID_OUT) begin
        check("byte_expected", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("data_out", bus.DATA_OUT, e.data);
          check("p_sync", bus.P_SYNC_OUT, e.sync);
        end
        if (bus.P_SYNC_OUT) begin
          sync_seen++;
          check("pkt_expected", 32'(order_q.size() != 0), 1);
          if (order_q.size() != 0) begin
            o = order_q.pop_front();
            check("cur_ch", bus.CUR_CH, o.ch);
            if (o.gap >= 0) check("gap", grun, o.gap);
          end
        end
        last_idx = vrun;
        vrun++;
        grun = 0;
        if (sb.size() == 0) last_cyc = cyc;
      end else begin
        check("sync_without_valid", bus.P_SYNC_OUT, 0);
        if (vrun != 0) begin
          check("pkt_len", vrun, PKT_LEN);
          vrun = 0;
        end
        grun++;
      end
    end
  end

  task automatic do_reset();
    bus.GOT_FULL_PACKET = '0;
    bus.SPI_ADDRESS = '0;
    bus.SPI_DATA = '0;
    bus.RISING_SS = 1'b0;
    rst = 1'b1;
    sb.delete();
    order_q.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic spi_write(input logic [7:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    bus.SPI_ADDRESS = a;
    bus.SPI_DATA = d;
    bus.RISING_SS = 1'b1;
    @(posedge clk); #1;
    bus.RISING_SS = 1'b0;
  endtask

  task automatic wait_syncs(input int n, input int budget);
    int target = sync_seen + n;
    int t = 0;
    while (sync_seen < target && t < budget) begin
      @(negedge clk); #1;
      t++;
    end
    check("wait_syncs", 32'(sync_seen >= target), 1);
  endtask

  task automatic wait_sb_empty(input int budget);
    int t = 0;
    do begin
      @(negedge clk); #1;
      t++;
    end while (sb.size() != 0 && t < budget);
    check("wait_sb_empty", 32'(sb.size() == 0), 1);
  endtask

  task automatic drain(input int budget);
    int t = 0;
    while ((sb.size() != 0 || order_q.size() != 0 || bus.D_VALID_OUT) && t < budget) begin
      @(negedge clk); #1;
      t++;
    end
    check("drain_pkts_left", order_q.size(), 0);
    repeat (20) @(posedge clk);
  endtask

  task automatic push_null(input int gap);
    for (int k = 0; k < PKT_LEN; k++) sb.push_back('{null_exp(k), k == 0});
    order_q.push_back('{7, gap});
  endtask

  task automatic push_order(input int ch, input int gap);
    order_q.push_back('{ch, gap});
  endtask

  initial begin
    int t;
    int x;
    #1 do_reset();
    @(negedge clk);
    check("reset_rd_req", bus.RD_REQ, 0);
    check("reset_data_out", bus.DATA_OUT, 0);
    check("reset_d_valid", bus.D_VALID_OUT, 0);
    check("reset_p_sync", bus.P_SYNC_OUT, 0);
    check("reset_cur_ch", bus.CUR_CH, 0);

    // Channels 0 and 2 ready: alternate with one-cycle gaps.
    push_order(0, -1); push_order(2, 1); push_order(0, 1); push_order(2, 1);
    bus.GOT_FULL_PACKET = 4'b0101;
    wait_syncs(4, 3000);
    bus.GOT_FULL_PACKET = '0;
    drain(1000);

    // All four ready: 0,1,2,3,0.
    do_reset();
    push_order(0, -1); push_order(1, 1); push_order(2, 1); push_order(3, 1); push_order(0, 1);
    bus.GOT_FULL_PACKET = 4'b1111;
    wait_syncs(5, 3000);
    bus.GOT_FULL_PACKET = '0;
    drain(1000);

    // Mask rewritten while channel 0 is in flight.
    do_reset();
    push_order(0, -1); push_order(1, 1); push_order(1, 1);
    bus.GOT_FULL_PACKET = 4'b0011;
    wait_syncs(1, 1000);
    spi_write(8'h10, 8'h02);
    wait_syncs(2, 2000);
    bus.GOT_FULL_PACKET = '0;
    drain(1000);

    // Null stuffing, then a source arriving exactly at the idle threshold.
    do_reset();
    push_null(-1);
    spi_write(8'h11, 8'h01);
    wait_sb_empty(1000);
    x = last_cyc;
    push_order(3, 16);
    do begin
      @(posedge clk); #1;
    end while (cyc < x + 14);
    bus.GOT_FULL_PACKET = 4'b1000;
    wait_syncs(1, 1000);
    bus.GOT_FULL_PACKET = '0;
    wait_sb_empty(1000);
    push_null(16);
    wait_syncs(1, 1000);
    spi_write(8'h11, 8'h00);
    drain(1000);

    // Reset mid-packet, then defaults (pointer and mask) take over again.
    do_reset();
    spi_write(8'h10, 8'h04);
    push_order(2, -1);
    bus.GOT_FULL_PACKET = 4'b1111;
    t = 0;
    while (last_idx != 100 && t < 1000) begin
      @(negedge clk); #1;
      t++;
    end
    check("reach_byte_100", last_idx, 100);
    rst = 1'b1;
    #1;
    check("midrst_rd_req", bus.RD_REQ, 0);
    check("midrst_data_out", bus.DATA_OUT, 0);
    check("midrst_d_valid", bus.D_VALID_OUT, 0);
    check("midrst_p_sync", bus.P_SYNC_OUT, 0);
    check("midrst_cur_ch", bus.CUR_CH, 0);
    sb.delete();
    order_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    push_order(0, -1); push_order(1, 1); push_order(2, 1); push_order(3, 1);
    wait_syncs(4, 3000);
    bus.GOT_FULL_PACKET = '0;
    drain(1000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
